// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: sequential instruction fetch with a prefetch FIFO,
// credit-limited in-flight requests and redirect flush of stale responses.
module instruction_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_request,
  output logic [31:0] mem_address,
  input  logic        mem_grant,
  input  logic        mem_response_valid,
  input  logic [31:0] mem_response_data,
  input  logic        decode_ready,
  output logic        fetch_valid,
  output logic [31:0] fetch_instruction,
  output logic [31:0] fetch_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [31:0]   pc_next_q, pc_next_d, resp_pc_q, resp_pc_d, target_pc;
  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   instr_d [DEPTH];
  logic [31:0]   fpc_q [DEPTH];
  logic [31:0]   fpc_d [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d, out_q, out_d, drop_q, drop_d;
  logic [CW:0]   used;
  logic          xfer, push, pop;
  // A word is counted against the credit from grant until decode takes it.
  assign used              = {1'b0, count_q} + {1'b0, out_q};
  assign mem_request       = !reset && !redirect && (used < (CW+1)'(DEPTH));
  assign mem_address       = pc_next_q;
  assign target_pc         = redirect_pc & ~32'h3;
  assign fetch_valid       = count_q != '0;
  assign fetch_instruction = fetch_valid ? instr_q[rd_q] : '0;
  assign fetch_pc          = fetch_valid ? fpc_q[rd_q] : '0;
  always_comb begin
    xfer      = mem_request && mem_grant;
    push      = mem_response_valid && drop_q == '0 && !redirect;
    pop       = fetch_valid && decode_ready && !redirect;
    out_d     = out_q + CW'(xfer) - CW'(mem_response_valid);
    drop_d    = redirect ? out_q - CW'(mem_response_valid)
                         : drop_q - CW'(mem_response_valid && drop_q != '0);
    count_d   = redirect ? '0 : count_q + CW'(push) - CW'(pop);
    rd_d      = redirect ? '0 : rd_q + AW'(pop);
    wr_d      = redirect ? '0 : wr_q + AW'(push);
    pc_next_d = redirect ? target_pc : pc_next_q + (xfer ? 32'd4 : 32'd0);
    resp_pc_d = redirect ? target_pc : resp_pc_q + (push ? 32'd4 : 32'd0);
    instr_d   = instr_q;
    fpc_d     = fpc_q;
    if (push) begin
      instr_d[wr_q] = mem_response_data;
      fpc_d[wr_q]   = resp_pc_q;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_next_q <= RESET_PC;
      resp_pc_q <= RESET_PC;
      rd_q      <= '0;
      wr_q      <= '0;
      count_q   <= '0;
      out_q     <= '0;
      drop_q    <= '0;
      instr_q   <= '{default: '0};
      fpc_q     <= '{default: '0};
    end else begin
      pc_next_q <= pc_next_d;
      resp_pc_q <= resp_pc_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      count_q   <= count_d;
      out_q     <= out_d;
      drop_q    <= drop_d;
      instr_q   <= instr_d;
      fpc_q     <= fpc_d;
    end
  end
endmodule
